// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - opcode constants and format encoding for the immediate generator
package imm_pkg;

    localparam int FMT_W = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RISC-V immediate decode, sign-extended to XLEN
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RV64_OPS   = 0,
    parameter int SYSTEM_IMM = 1
) (
    input  logic [31:0]      i_instr,
    output logic [XLEN-1:0]  o_imm,
    output logic [FMT_W-1:0] o_fmt,
    output logic             o_illegal
);

    // OP-IMM-32 only exists on RV64
    localparam bit OPIMM32_EN = (XLEN == 64) && (RV64_OPS != 0);
    localparam bit SYSTEM_EN  = (SYSTEM_IMM != 0);

    fmt_e        w_fmt;
    logic [31:0] w_raw;

    always_comb begin
        w_fmt = FMT_NONE;
        w_raw = '0;
        case (i_instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                w_fmt = FMT_U;
                w_raw = {i_instr[31:12], 12'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_MISCMEM: begin
                w_fmt = FMT_I;
                w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            OPC_OPIMM32: begin
                if (OPIMM32_EN) begin
                    w_fmt = FMT_I;
                    w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
                end
            end
            OPC_SYSTEM: begin
                if (SYSTEM_EN) begin
                    w_fmt = FMT_I;
                    w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
                end
            end
            OPC_STORE: begin
                w_fmt = FMT_S;
                w_raw = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            OPC_BRANCH: begin
                w_fmt = FMT_B;
                w_raw = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
            end
            OPC_JAL: begin
                w_fmt = FMT_J;
                w_raw = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_wide
            assign o_imm = {{(XLEN-32){w_raw[31]}}, w_raw};
        end else begin : g_narrow
            assign o_imm = w_raw;
        end
    endgenerate

    assign o_fmt     = w_fmt;
    assign o_illegal = (w_fmt == FMT_NONE);

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with a 2-entry skid buffer
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RV64_OPS   = 0,
    parameter int SYSTEM_IMM = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  imm,
    output logic [FMT_W-1:0] fmt,
    output logic             illegal
);

    logic [XLEN-1:0]  w_dec_imm;
    logic [FMT_W-1:0] w_dec_fmt;
    logic             w_dec_ill;

    imm_decode #(
        .XLEN       (XLEN),
        .RV64_OPS   (RV64_OPS),
        .SYSTEM_IMM (SYSTEM_IMM)
    ) u_decode (
        .i_instr   (instr),
        .o_imm     (w_dec_imm),
        .o_fmt     (w_dec_fmt),
        .o_illegal (w_dec_ill)
    );

    // M drives the outputs; K catches the one word in flight when M stalls
    logic             r_m_valid, r_k_valid;
    logic [31:0]      r_m_instr, r_k_instr;
    logic [XLEN-1:0]  r_m_imm,   r_k_imm;
    logic [FMT_W-1:0] r_m_fmt,   r_k_fmt;
    logic             r_m_ill,   r_k_ill;

    logic w_accept;
    logic w_drain;

    assign w_accept = in_valid && !r_k_valid;
    assign w_drain  = r_m_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_k_valid <= 1'b0;
            r_m_instr <= '0;
            r_m_imm   <= '0;
            r_m_fmt   <= FMT_NONE;
            r_m_ill   <= 1'b0;
            r_k_instr <= '0;
            r_k_imm   <= '0;
            r_k_fmt   <= FMT_NONE;
            r_k_ill   <= 1'b0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_k_valid <= 1'b0;
        end else if (w_drain) begin
            if (r_k_valid) begin
                r_m_instr <= r_k_instr;
                r_m_imm   <= r_k_imm;
                r_m_fmt   <= r_k_fmt;
                r_m_ill   <= r_k_ill;
                r_k_valid <= 1'b0;
            end else if (w_accept) begin
                r_m_instr <= instr;
                r_m_imm   <= w_dec_imm;
                r_m_fmt   <= w_dec_fmt;
                r_m_ill   <= w_dec_ill;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_m_valid) begin
                r_m_valid <= 1'b1;
                r_m_instr <= instr;
                r_m_imm   <= w_dec_imm;
                r_m_fmt   <= w_dec_fmt;
                r_m_ill   <= w_dec_ill;
            end else begin
                r_k_valid <= 1'b1;
                r_k_instr <= instr;
                r_k_imm   <= w_dec_imm;
                r_k_fmt   <= w_dec_fmt;
                r_k_ill   <= w_dec_ill;
            end
        end
    end

    assign in_ready  = !r_k_valid;
    assign out_valid = r_m_valid;
    assign out_instr = r_m_instr;
    assign imm       = r_m_imm;
    assign fmt       = r_m_fmt;
    assign illegal   = r_m_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - randomized and directed bench for imm_gen_pipe (RV32 and RV64 builds)
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr;

    logic        rdy32, vld32, ill32;
    logic [31:0] oi32, imm32;
    logic [2:0]  fmt32;
    logic        rdy64, vld64, ill64;
    logic [31:0] oi64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;

    imm_gen_pipe #(.XLEN(32), .RV64_OPS(0), .SYSTEM_IMM(1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .instr(instr), .out_valid(vld32), .out_ready(out_ready), .out_instr(oi32),
        .imm(imm32), .fmt(fmt32), .illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .RV64_OPS(1), .SYSTEM_IMM(0)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .instr(instr), .out_valid(vld64), .out_ready(out_ready), .out_instr(oi64),
        .imm(imm64), .fmt(fmt64), .illegal(ill64)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;
    logic [31:0] q[$];
    bit m_pop, m_push;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference decode. is64 selects the RV64 build (OP-IMM-32 on, SYSTEM off).
    function automatic void ref_dec(input logic [31:0] ins, input bit is64,
                                    output logic [63:0] e_imm, output logic [2:0] e_fmt);
        int     x;
        int     s;
        longint s64;
        x = int'(ins);
        s = 0;
        e_fmt = 3'd0;
        case (ins[6:0])
            7'h37, 7'h17: begin e_fmt = 3'd4; s = int'(ins & 32'hFFFF_F000); end
            7'h67, 7'h03, 7'h13, 7'h0F: begin e_fmt = 3'd1; s = x >>> 20; end
            7'h1B: if (is64) begin e_fmt = 3'd1; s = x >>> 20; end
            7'h73: if (!is64) begin e_fmt = 3'd1; s = x >>> 20; end
            7'h23: begin e_fmt = 3'd2; s = (x >>> 25) * 32 + int'(ins[11:7]); end
            7'h63: begin
                e_fmt = 3'd3;
                s = (x >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                    + int'(ins[11:8]) * 2;
            end
            7'h6F: begin
                e_fmt = 3'd5;
                s = (x >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                    + int'(ins[30:21]) * 2;
            end
            default: ;
        endcase
        s64 = longint'(s);
        e_imm = is64 ? s64 : (s64 & 64'h0000_0000_FFFF_FFFF);
    endfunction

    // Transaction model: a FIFO of capacity two
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            m_pop  = (q.size() > 0) && out_ready;
            m_push = in_valid && (q.size() < 2);
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(instr);
        end
    end

    always @(negedge clk) begin
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        if (chk_en && rst_n) begin
            check("out_valid32", vld32, q.size() > 0);
            check("in_ready32", rdy32, q.size() < 2);
            check("out_valid64", vld64, q.size() > 0);
            check("in_ready64", rdy64, q.size() < 2);
            if (q.size() > 0) begin
                ref_dec(q[0], 1'b0, e_imm, e_fmt);
                check("out_instr32", oi32, q[0]);
                check("imm32", imm32, e_imm);
                check("fmt32", fmt32, e_fmt);
                check("illegal32", ill32, e_fmt == 3'd0);
                ref_dec(q[0], 1'b1, e_imm, e_fmt);
                check("out_instr64", oi64, q[0]);
                check("imm64", imm64, e_imm);
                check("fmt64", fmt64, e_fmt);
                check("illegal64", ill64, e_fmt == 3'd0);
            end
        end
    end

    task automatic dir(input logic [31:0] ins, input logic [63:0] e32, input logic [2:0] f32,
                       input logic [63:0] e64, input logic [2:0] f64);
        logic [63:0] m_imm;
        logic [2:0]  m_fmt;
        ref_dec(ins, 1'b0, m_imm, m_fmt);
        check($sformatf("pin_imm32_%h", ins), m_imm, e32);
        ref_dec(ins, 1'b1, m_imm, m_fmt);
        check($sformatf("pin_imm64_%h", ins), m_imm, e64);
        @(negedge clk);
        in_valid = 1'b1; instr = ins; out_ready = 1'b1; flush = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("dir_valid_%h", ins), vld32, 1'b1);
        check($sformatf("dir_imm32_%h", ins), imm32, e32);
        check($sformatf("dir_fmt32_%h", ins), fmt32, f32);
        check($sformatf("dir_ill32_%h", ins), ill32, f32 == 3'd0);
        check($sformatf("dir_imm64_%h", ins), imm64, e64);
        check($sformatf("dir_fmt64_%h", ins), fmt64, f64);
        check($sformatf("dir_ill64_%h", ins), ill64, f64 == 3'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [14] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                  7'h13, 7'h1B, 7'h0F, 7'h73, 7'h33, 7'h00, 7'h7F};
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 13)];
        return r;
    endfunction

    initial begin
        int bias;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
        #1;
        check("rst_out_valid", vld32, 1'b0);
        check("rst_in_ready", rdy32, 1'b1);
        check("rst_imm", imm32, 64'd0);
        check("rst_fmt", fmt32, 3'd0);
        check("rst_out_instr", oi32, 32'd0);
        check("rst_illegal", ill32, 1'b0);
        check("rst_imm64", imm64, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        dir(32'hFFF00093, 64'hFFFF_FFFF, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
        dir(32'hFE000EE3, 64'hFFFF_FFFC, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3);
        dir(32'hFE112E23, 64'hFFFF_FFFC, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2);
        dir(32'h0080006F, 64'h0000_0008, 3'd5, 64'h0000_0000_0000_0008, 3'd5);
        dir(32'h12345037, 64'h1234_5000, 3'd4, 64'h0000_0000_1234_5000, 3'd4);
        dir(32'h80000037, 64'h8000_0000, 3'd4, 64'hFFFF_FFFF_8000_0000, 3'd4);
        dir(32'hFFFFF017, 64'hFFFF_F000, 3'd4, 64'hFFFF_FFFF_FFFF_F000, 3'd4);
        dir(32'hFFF0009B, 64'h0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
        dir(32'h30002573, 64'h0000_0300, 3'd1, 64'h0, 3'd0);
        dir(32'h00000033, 64'h0, 3'd0, 64'h0, 3'd0);
        dir(32'h00000000, 64'h0, 3'd0, 64'h0, 3'd0);

        // backpressure: A, B accepted, C held until the consumer drains
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFFF00093;
        @(negedge clk);
        instr = 32'h0080006F;
        @(negedge clk);
        check("bp_in_ready_low", rdy32, 1'b0);
        check("bp_hold_a", oi32, 32'hFFF00093);
        instr = 32'h12345037;
        @(negedge clk);
        check("bp_stable_a", oi32, 32'hFFF00093);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_out_b", oi32, 32'h0080006F);
        check("bp_in_ready_high", rdy32, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_out_c", oi32, 32'h12345037);
        @(negedge clk);
        check("bp_empty", vld32, 1'b0);

        // flush with both entries full and a new word offered
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00100093;
        @(negedge clk);
        instr = 32'h00200093;
        @(negedge clk);
        check("fl_full", rdy32, 1'b0);
        flush = 1'b1; instr = 32'h00300093;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", vld32, 1'b0);
        check("fl_ready", rdy32, 1'b1);
        check("fl_valid64", vld64, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        check("fl_nothing", vld32, 1'b0);

        // randomized traffic with varying consumer stall bias
        bias = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i % 100 == 0) bias = $urandom_range(0, 3);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) >= bias);
            flush     = ($urandom_range(0, 49) == 0);
            instr     = rand_instr();
        end

        // reset in the middle of a stream
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500093;
        @(negedge clk);
        instr = 32'h00600093;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", vld32, 1'b0);
        check("mid_rst_ready", rdy32, 1'b1);
        check("mid_rst_imm", imm32, 64'd0);
        check("mid_rst_valid64", vld64, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
